// File: rtl/line_pkg.sv
// line_pkg: shared width, FSM state encoding and coordinate type for the line-drawing core.
package line_pkg;
  localparam int LINE_WIDTH = 13;
  typedef enum logic [2:0] {IDLE, SETUP, INIT, DRAW, DONE} state_t;
  typedef logic signed [LINE_WIDTH-1:0] coord_t;
endpackage

// File: rtl/divide_by_two.sv
// divide_by_two: signed halving by arithmetic shift right (floor for non-negative inputs).
module divide_by_two #(
  parameter int W = 14
) (
  input  logic signed [W-1:0] i_val,
  output logic signed [W-1:0] o_half
);
  assign o_half = i_val >>> 1;
endmodule

// File: rtl/line_step_ctrl.sv
// line_step_ctrl: Bresenham line sequencer emitting one pixel per valid/ready handshake.
// LINE_OMIT_LAST_PIXEL_EN drops the endpoint so that shared polygon edges are half-open.
module line_step_ctrl
  import line_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  input  logic                    abort,
  output logic                    busy,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic signed [WIDTH-1:0] pix_x,
  output logic signed [WIDTH-1:0] pix_y,
  output logic                    done
);
  localparam int AW = WIDTH + 1;
`ifdef LINE_OMIT_LAST_PIXEL_EN
  localparam logic signed [AW-1:0] LAST = AW'(1);
`else
  localparam logic signed [AW-1:0] LAST = AW'(0);
`endif
  state_t                  r_state;
  logic signed [WIDTH-1:0] r_x0, r_y0, r_x1, r_y1;
  logic signed [AW-1:0]    r_major, r_minor, r_err, r_rem;
  logic                    r_xneg, r_yneg, r_steep;
  logic signed [AW-1:0]    w_dx, w_dy, w_adx, w_ady, w_major, w_minor, w_half, w_err_sub;
  logic signed [WIDTH-1:0] w_xs, w_ys, w_x_next, w_y_next;
  logic                    w_steep, w_hs, w_last, w_empty;

  assign w_dx      = {r_x1[WIDTH-1], r_x1} - {r_x0[WIDTH-1], r_x0};
  assign w_dy      = {r_y1[WIDTH-1], r_y1} - {r_y0[WIDTH-1], r_y0};
  assign w_adx     = w_dx[AW-1] ? -w_dx : w_dx;
  assign w_ady     = w_dy[AW-1] ? -w_dy : w_dy;
  assign w_steep   = w_ady > w_adx;
  assign w_major   = w_steep ? w_ady : w_adx;
  assign w_minor   = w_steep ? w_adx : w_ady;
  assign w_hs      = pix_valid && pix_ready;
  assign w_last    = r_rem == LAST;
  assign w_err_sub = r_err - r_minor;
  assign w_xs      = r_xneg ? '1 : WIDTH'(1);
  assign w_ys      = r_yneg ? '1 : WIDTH'(1);
  // The major axis always advances; the minor axis only when the error goes negative.
  assign w_x_next  = pix_x + ((!r_steep || w_err_sub[AW-1]) ? w_xs : '0);
  assign w_y_next  = pix_y + ((r_steep || w_err_sub[AW-1]) ? w_ys : '0);
`ifdef LINE_OMIT_LAST_PIXEL_EN
  assign w_empty   = r_rem == '0;
`else
  assign w_empty   = 1'b0;
`endif

  divide_by_two #(.W(AW)) u_half (
    .i_val  (r_major),
    .o_half (w_half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_major   <= '0;
      r_minor   <= '0;
      r_err     <= '0;
      r_rem     <= '0;
      r_xneg    <= 1'b0;
      r_yneg    <= 1'b0;
      r_steep   <= 1'b0;
      busy      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_x0    <= x0;
          r_y0    <= y0;
          r_x1    <= x1;
          r_y1    <= y1;
          busy    <= 1'b1;
          r_state <= SETUP;
        end
        SETUP: if (abort) begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_major <= w_major;
          r_minor <= w_minor;
          r_rem   <= w_major;
          r_xneg  <= w_dx[AW-1];
          r_yneg  <= w_dy[AW-1];
          r_steep <= w_steep;
          pix_x   <= r_x0;
          pix_y   <= r_y0;
          r_state <= INIT;
        end
        INIT: if (abort) begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_err     <= w_half;
          done      <= w_empty;
          pix_valid <= !w_empty;
          r_state   <= w_empty ? DONE : DRAW;
        end
        DRAW: if (abort) begin
          busy      <= 1'b0;
          pix_valid <= 1'b0;
          r_state   <= IDLE;
        end else if (w_hs && w_last) begin
          pix_valid <= 1'b0;
          done      <= 1'b1;
          r_state   <= DONE;
        end else if (w_hs) begin
          pix_x <= w_x_next;
          pix_y <= w_y_next;
          r_err <= w_err_sub[AW-1] ? w_err_sub + r_major : w_err_sub;
          r_rem <= r_rem - AW'(1);
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_step_ctrl.sv
// tb_line_step_ctrl: directed checks of pixel sequences, stalls, abort, reset and degenerate lines.
module tb_line_step_ctrl;
  import line_pkg::*;
  logic   clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, pix_ready = 1'b0;
  coord_t x0 = '0, y0 = '0, x1 = '0, y1 = '0, pix_x, pix_y;
  logic   busy, pix_valid, done;
  int     checks = 0, failures = 0;

  line_step_ctrl #(.WIDTH(LINE_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .abort     (abort),
    .busy      (busy),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives start there and follows the line to its done pulse.
  task automatic run_line(input string tag, input int ax0, input int ay0, input int ax1, input int ay1,
                          input int ex[$], input int ey[$], input bit tog);
    int k = 0;
    int last_hs = -1;
    bit fin = 1'b0;
`ifdef LINE_OMIT_LAST_PIXEL_EN
    void'(ex.pop_back());
    void'(ey.pop_back());
`endif
    x0 = coord_t'(ax0); y0 = coord_t'(ay0); x1 = coord_t'(ax1); y1 = coord_t'(ay1);
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_on"}, busy, 1);
    chk({tag, ".valid_early1"}, pix_valid, 0);
    @(negedge clk);
    chk({tag, ".valid_early2"}, pix_valid, 0);
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (tog && c == 4) begin
        start = 1'b1;
        x1 = coord_t'(-9);
      end else start = 1'b0;
      if (c == 0 && ex.size() > 0) chk({tag, ".first_valid"}, pix_valid, 1);
      if (done) begin
        chk({tag, ".count"}, k, ex.size());
        chk({tag, ".done_lat"}, c, last_hs + 1);
        chk({tag, ".valid_at_done"}, pix_valid, 0);
        fin = 1'b1;
      end else if (pix_valid) begin
        if (k < ex.size()) begin
          chk($sformatf("%s.x%0d", tag, k), pix_x, ex[k]);
          chk($sformatf("%s.y%0d", tag, k), pix_y, ey[k]);
        end else chk({tag, ".extra_pixel"}, pix_valid, 0);
        pix_ready = tog ? (c % 3 == 0) : 1'b1;
        if (pix_ready) begin
          k++;
          last_hs = c;
        end
      end
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, fin, 1);
    @(negedge clk);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".done_once"}, done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.valid", pix_valid, 0);
    chk("rst.done", done, 0);
    chk("rst.x", pix_x, 0);
    chk("rst.y", pix_y, 0);
    rst = 1'b0;
    @(negedge clk);
    run_line("shallow", 0, 0, 5, 2, '{0, 1, 2, 3, 4, 5}, '{0, 0, 1, 1, 2, 2}, 1'b0);
    run_line("steep", 0, 0, 1, 4, '{0, 0, 0, 1, 1}, '{0, 1, 2, 3, 4}, 1'b0);
    run_line("neg", 3, 3, 0, 0, '{3, 2, 1, 0}, '{3, 2, 1, 0}, 1'b0);
    run_line("stall", 0, 0, 5, 2, '{0, 1, 2, 3, 4, 5}, '{0, 0, 1, 1, 2, 2}, 1'b1);
    run_line("degen", 7, -4, 7, -4, '{7}, '{-4}, 1'b0);
    // abort on the third DRAW cycle, then restart straight away
    x0 = 0; y0 = 0; x1 = 5; y1 = 2;
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.x_before", pix_x, 2);
    chk("abort.y_before", pix_y, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.valid", pix_valid, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    run_line("restart", 0, 0, 2, 0, '{0, 1, 2}, '{0, 0, 0}, 1'b0);
    // asynchronous reset in the middle of a line
    x0 = 0; y0 = 0; x1 = 5; y1 = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.x_before", pix_x, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", pix_valid, 0);
    chk("arst.busy", busy, 0);
    chk("arst.x", pix_x, 0);
    chk("arst.y", pix_y, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.no_done", done, 0);
    chk("arst.idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_step_ctrl.md
Name: line_step_ctrl

Overview:
- Sequencing controller for the line-drawing core.
- Accepts one line (two endpoints) per command and runs Bresenham stepping across all octants.
- Emits one pixel per valid/ready handshake to the downstream pixel writer.
- Forms the initial error term as major_delta/2 through the codebase's divide_by_two unit. Sits between the primitive-setup stage and the framebuffer write stage.

Parameters:
- WIDTH, 13, signed two's-complement coordinate width.
- Internal arithmetic (deltas, error) uses WIDTH+1 bits, so no overflow occurs over the full signed input range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- x0  in  WIDTH  start x, signed.
- y0  in  WIDTH  start y, signed.
- x1  in  WIDTH  end x, signed.
- y1  in  WIDTH  end y, signed.
- abort  in  1  synchronous cancel of the current line.
- busy  out  1  high from the accepting edge until return to IDLE.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  WIDTH  pixel x.
- pix_y  out  WIDTH  pixel y.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, pix_valid and done = 0; pix_x, pix_y = 0; all internal registers cleared. Reset mid-line discards the line; no done pulse.
- States: IDLE -> SETUP -> INIT -> DRAW -> DONE -> IDLE.
- IDLE: on start=1, latch endpoints; busy=1 from the next cycle; go to SETUP. start while busy=1 is ignored.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=|y1-y0|.
  - xstep=+1 if x1>=x0, else -1; ystep likewise.
  - steep = dy>dx. Major delta = steep ? dy : dx; minor delta = the other.
  - Load pix_x=x0, pix_y=y0, remaining=major.
- INIT (1 cycle): err = major/2 via divide_by_two (arithmetic shift right; major>=0, so this is floor). Then go to DRAW.
- DRAW:
  - pix_valid=1; first pix_valid appears 3 cycles after the start edge.
  - Without handshake (pix_valid && !pix_ready), pix_x, pix_y and all state hold.
  - On handshake with remaining=0: go to DONE; pix_valid=0 next cycle.
  - On handshake otherwise:
    - Step the major axis by its step; err -= minor.
    - If the result is <0: step the minor axis and err += major.
    - remaining -= 1.
    - Back-to-back handshakes give one pixel per clock.
- DONE: done=1 for exactly one cycle; busy=0 in the following cycle (IDLE). A new start is accepted in that IDLE cycle at the earliest.
- abort=1 in SETUP, INIT or DRAW: next state IDLE, pix_valid=0, busy=0, no done. abort in IDLE or DONE has no effect. If abort and a handshake occur in the same cycle, the pixel counts as delivered and abort still wins.
- Degenerate line (x0==x1, y0==y1): exactly one pixel (x0,y0), then done.
- Pixel count = major+1. The sequence is independent of pix_ready timing.

Optional Feature:
- Macro LINE_OMIT_LAST_PIXEL_EN.
- Defined: the endpoint (x1,y1) is not emitted and pixel count = major. The DRAW exit test becomes remaining=1 on handshake. A degenerate line goes INIT -> DONE with zero pixels and done still pulses. This gives half-open lines for shared polygon edges.
- Undefined: behaviour as above, endpoint inclusive.

Decomposition:
- Shared package line_pkg holds:
  - LINE_WIDTH=13 constant.
  - State enum (IDLE, SETUP, INIT, DRAW, DONE), 3-bit encoding.
  - Signed coordinate typedef.
- One sub-module: an instance of the existing divide_by_two (WIDTH+1) for the INIT error term. The abs/step logic stays inline.

Test Plan:
- (0,0)->(5,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on consecutive cycles; first pix_valid 3 cycles after start; done 1 cycle after the last handshake.
- Steep (0,0)->(1,4) -> (0,0),(0,1),(0,2),(1,3),(1,4).
- Negative direction (3,3)->(0,0) -> (3,3),(2,2),(1,1),(0,0). With LINE_OMIT_LAST_PIXEL_EN defined -> (3,3),(2,2),(1,1) only.
- (0,0)->(5,2) with pix_ready toggling 1,0,0,1... -> same 6-pixel sequence; pix_x/pix_y stable while stalled; start pulsed mid-line is ignored.
- Degenerate (7,-4)->(7,-4) -> a single pixel (7,-4) then done. With LINE_OMIT_LAST_PIXEL_EN -> no pixel, done still pulses.
- Cases on (0,0)->(5,2):
  - abort asserted on the 3rd DRAW cycle -> pix_valid and busy low next cycle, no done; an immediately following start (0,0)->(2,0) gives (0,0),(1,0),(2,0).
  - rst asserted mid-line -> outputs 0 asynchronously.
